// File: rtl/word_adder_driver.sv
// word_adder_driver: issues load/enable/settle command sequences to word_adder and returns its result; WORD_DRV_B2B_EN enables back-to-back requests
module word_adder_driver #(
  parameter int WIDTH  = 9,
  parameter int CNT_W  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_word,
  input  logic [CNT_W-1:0] req_steps,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [1:0]       func,
  output logic [WIDTH-1:0] inWord,
  input  logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] W_LAST = SW'(SETTLE - 1);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, STEP = 3'd2, WAIT = 3'd3, RESP = 3'd4;
  logic [2:0]       state;
  logic [WIDTH-1:0] op;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    wcnt;
  logic             take;
`ifdef WORD_DRV_B2B_EN
  assign req_ready = !rst && (state == IDLE || (state == RESP && rsp_ready));
`else
  assign req_ready = !rst && state == IDLE;
`endif
  assign take      = req_valid && req_ready;
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  assign inWord    = op;
  // command pins follow the state: load in LOAD, enable in STEP, idle elsewhere
  always_comb func = state == LOAD ? 2'd1 : state == STEP ? 2'd2 : 2'd0;
  // sequencer: latch request, count enables, count settle window, hold response
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op         <= '0;
      cnt        <= '0;
      wcnt       <= '0;
      rsp_result <= '0;
    end else begin
      if (take) begin
        op  <= req_word;
        cnt <= req_steps;
      end
      case (state)
        IDLE: if (take) state <= LOAD;
        LOAD: begin
          state <= cnt != '0 ? STEP : WAIT;
          wcnt  <= '0;
        end
        STEP: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == W_LAST) begin
            rsp_result <= result;
            state      <= RESP;
          end
        end
        RESP: if (rsp_ready) state <= take ? LOAD : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_word_adder_driver.sv
// tb_word_adder_driver: scoreboard bench driving word_adder_driver against a word_adder model (+3 per enable)
module tb_word_adder_driver;
  localparam int SETTLE = 2;
  logic       clk = 0, rst = 1;
  logic       req_valid = 0, rsp_ready = 0;
  logic [8:0] req_word = '0;
  logic [3:0] req_steps = '0;
  logic       req_ready, rsp_valid, busy;
  logic [8:0] rsp_result, inWord, result, acc;
  logic [1:0] func;
  logic [8:0] sb[$];
  int total = 0, bad = 0;

  word_adder_driver #(.WIDTH(9), .CNT_W(4), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_word(req_word), .req_steps(req_steps), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .func(func),
    .inWord(inWord), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst) acc <= '0;
    else if (func == 2'd1) acc <= inWord;
    else if (func == 2'd2) acc <= acc + 9'd3;
  assign result = acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [8:0] w, input int n);
    req_valid = 1;
    req_word  = w;
    req_steps = 4'(n);
    #0;
    check("req_ready_idle", req_ready, 1);
    sb.push_back(w + 9'(3 * n));
    step();
    req_valid = 0;
  endtask

  task automatic after_load(input logic [8:0] w, input int n, input int hold);
    logic [8:0] held;
    check("load_func", func, 1);
    check("load_word", inWord, w);
    for (int i = 0; i < n; i++) begin
      step();
      check("step_func", func, 2);
      check("step_rdy", req_ready, 0);
    end
    for (int i = 0; i < SETTLE; i++) begin
      step();
      check("wait_func", func, 0);
      check("wait_rv", rsp_valid, 0);
    end
    step();
    check("rsp_rise", rsp_valid, 1);
    held = rsp_result;
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", rsp_valid, 1);
      check("hold_result", rsp_result, held);
      check("hold_rdy", req_ready, 0);
      check("hold_func", func, 0);
    end
  endtask

  task automatic pop_cmp();
    logic [8:0] e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got response %0h expected none", rsp_result);
    end else begin
      e = sb.pop_front();
      check("rsp_result", rsp_result, e);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1;
    #0;
    check("rsp_valid_hs", rsp_valid, 1);
    pop_cmp();
    step();
    rsp_ready = 0;
    check("rsp_drop", rsp_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    step();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_func", func, 0);
    check("rst_inword", inWord, 0);
    check("rst_busy", busy, 0);
    check("rst_result", rsp_result, 0);
    rst = 0;
    #1;
    check("post_rst_ready", req_ready, 1);

    issue(9'h0A5, 0); after_load(9'h0A5, 0, 0); finish_rsp();
    issue(9'h123, 3); after_load(9'h123, 3, 0); finish_rsp();
    issue(9'h055, 2); after_load(9'h055, 2, 5); finish_rsp();

    issue(9'h077, 5);
    check("mid_load", func, 1);
    step(); check("mid_step1", func, 2);
    step(); check("mid_step2", func, 2);
    rst = 1;
    step();
    rst = 0;
    check("mid_rst_func", func, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rv", rsp_valid, 0);
    void'(sb.pop_back());
    for (int i = 0; i < 8; i++) begin
      step();
      check("mid_no_rsp", rsp_valid, 0);
    end
    issue(9'h100, 4); after_load(9'h100, 4, 0); finish_rsp();

    issue(9'h1F0, 15); after_load(9'h1F0, 15, 0); finish_rsp();

    issue(9'h010, 1); after_load(9'h010, 1, 0);
    rsp_ready = 1;
    req_valid = 1;
    req_word  = 9'h0C0;
    req_steps = 4'd2;
    #0;
    check("b2b_rv", rsp_valid, 1);
    pop_cmp();
`ifdef WORD_DRV_B2B_EN
    check("b2b_rdy", req_ready, 1);
    sb.push_back(9'h0C0 + 9'd6);
    step();
    rsp_ready = 0;
    req_valid = 0;
`else
    check("b2b_rdy", req_ready, 0);
    step();
    rsp_ready = 0;
    check("b2b_bubble", func, 0);
    issue(9'h0C0, 2);
`endif
    after_load(9'h0C0, 2, 0);
    finish_rsp();
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/word_adder_driver.md
# word_adder_driver

Command initiator for the `word_adder` datapath. It accepts one request per transaction (operand word plus step count) on a valid/ready port, then drives the `func`/`inWord` command pins of `word_adder`:

- one load command,
- then N enable commands,
- then idle for a fixed settle window.

It samples the `word_adder` result and returns it on a valid/ready response port. It sits between the test/control logic and `word_adder`, the issuing end of that block's command interface.

## Interface
Parameters:
- WIDTH, 9, operand/result width; matches word_adder data width
- CNT_W, 4, width of the step count; maximum steps = 2^CNT_W-1
- SETTLE, 2, idle cycles after the last command before the result is sampled; legal range ≥1

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  driver can accept a request
- req_word  input  WIDTH  operand to load
- req_steps  input  CNT_W  number of enable cycles to issue
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  WIDTH  sampled word_adder result
- func  output  2  command to word_adder: 0 idle, 1 load, 2 enable; 3 never driven
- inWord  output  WIDTH  load operand to word_adder
- result  input  WIDTH  word_adder result
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, STEP, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_word into the operand register and req_steps into the step counter, then go to LOAD.
- LOAD:
  - One cycle, func=1.
  - Go to STEP if the step count is nonzero, else go to WAIT.
- STEP:
  - func=2 for exactly req_steps consecutive cycles.
  - The counter decrements each cycle; leave for WAIT in the cycle the counter equals 1.
- WAIT:
  - func=0 for SETTLE cycles.
  - On the last WAIT cycle, register `result` into rsp_result and go to RESP.
- RESP:
  - rsp_valid=1; rsp_result holds stable.
  - On rsp_ready, go to IDLE.
  - rsp_valid must not drop before the handshake completes.
- func=0 in IDLE, WAIT and RESP.
- inWord always drives the operand register, including outside LOAD.
- req_ready=0 in all states except IDLE; req inputs are ignored while busy.
- Reset value of every output: req_ready=0 during the rst cycle, then 1 in IDLE afterward. rsp_valid=0, rsp_result=0, func=0, inWord=0, busy=0.
- Reset mid-transaction: abort immediately and return to IDLE. No response is emitted, and func=0 from the cycle after rst is sampled.
- Step count 0: only the load is issued, and the result reflects the loaded word after the settle window.

## Timing
- Request handshake in cycle T. LOAD is in T+1. STEP covers T+2 .. T+1+steps. WAIT covers the next SETTLE cycles. rsp_valid first rises in T+2+steps+SETTLE.
- The response is held indefinitely under rsp_ready=0.
- Without the configuration macro, the earliest next request handshake is one cycle after the response handshake.

## Configuration
- Macro WORD_DRV_B2B_EN.
- Defined:
  - In RESP, req_ready = rsp_ready.
  - A simultaneous response handshake and request handshake latch the new request and go straight to LOAD, giving back-to-back transactions with no IDLE bubble.
- Undefined: req_ready=0 in RESP; always return through IDLE.

## Test plan
- Reset, then req_word=9'h0A5, req_steps=0, SETTLE=2. Required: func sequence 1,0,0; inWord=9'h0A5 in LOAD; rsp_valid rises at T+4 with rsp_result equal to `result` sampled in the final WAIT cycle.
- req_steps=3. Required: func=1 for one cycle, then 2 for exactly 3 cycles, then 0; rsp_valid at T+7.
- rsp_ready held low 5 cycles in RESP. Required: rsp_valid and rsp_result stable; req_ready=0; no func activity.
- rst asserted on the 2nd STEP cycle of a req_steps=5 transaction. Required: func=0 the next cycle; state IDLE; no rsp_valid; a new request is accepted normally afterward.
- Maximum req_steps=4'hF. Required: exactly 15 enable cycles; no counter wrap.
- With WORD_DRV_B2B_EN, req_valid held high across the response handshake. Required: the next LOAD occurs in the cycle after the handshake; without the macro, it occurs one cycle later.
